// File: rtl/xgmii_probe_rx.sv
// XGMII RX probe parser: per-second frame/byte/probe counters and one-way probe latency.
// Optional per-window latency min/max outputs are enabled with PROBE_RX_MINMAX_EN.
`timescale 1ns/1ps
module xgmii_probe_rx #(
  parameter logic [39:0] MAGIC_CODE = 40'hA1B2C3D4E5,
  parameter logic [15:0] UDP_PORT   = 16'h0D5E
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic [31:0] global_counter,
  input  logic        sec_oneshot,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput,
  output logic [31:0] rx_probe_count,
  output logic [23:0] rx_latency,
  output logic        rx_probe_valid,
  output logic [31:0] rx_ipv4_ip
`ifdef PROBE_RX_MINMAX_EN
  ,
  output logic [23:0] rx_latency_min,
  output logic [23:0] rx_latency_max
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_TERM, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [15:0] w;
  logic        chk_ok;
  logic [7:0]  ts_b3;
  logic [31:0] ip_shadow;
  logic        commit_pend;
  logic [23:0] lat_pend;
  logic [31:0] term_bytes;
  logic [31:0] frame_acc, byte_acc, probe_acc;

  logic        term_found, err_fe, is_start, is_idle;
  logic [2:0]  term_k;
  logic [31:0] ts, dlt;
  logic [23:0] lat_sat;
  logic [31:0] inc_b;
  logic        inc_f;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  function automatic logic [7:0] lane(input logic [63:0] d, input int unsigned i);
    return d[8*i +: 8];
  endfunction

  // Lowest-lane terminate wins; an FE in any control lane marks the word bad.
  always_comb begin
    term_found = 1'b0;
    term_k     = '0;
    err_fe     = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (xgmii_rxc[i] && lane(xgmii_rxd, i) == 8'hFD && !term_found) begin
        term_found = 1'b1;
        term_k     = 3'(i);
      end
      if (xgmii_rxc[i] && lane(xgmii_rxd, i) == 8'hFE) err_fe = 1'b1;
    end
  end

  assign is_start = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == 8'hFB);
  assign is_idle  = (xgmii_rxc == 8'hFF);

  assign ts      = {ts_b3, xgmii_rxd[7:0], xgmii_rxd[15:8], xgmii_rxd[23:16]};
  assign dlt     = global_counter - ts;
  assign lat_sat = (|dlt[31:24]) ? '1 : dlt[23:0];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (is_start) state_nxt = S_HDR;
      S_HDR: begin
        if (err_fe)          state_nxt = (term_found || is_idle) ? S_IDLE : S_DROP;
        else if (term_found) state_nxt = S_TERM;
        else if (is_idle)    state_nxt = S_IDLE;
        else                 state_nxt = S_HDR;
      end
      S_TERM: state_nxt = is_start ? S_HDR : S_IDLE;
      S_DROP: if (term_found || is_idle) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Frame parsing: word index, probe header checks, IP/timestamp capture.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      w           <= '0;
      chk_ok      <= 1'b0;
      ts_b3       <= '0;
      ip_shadow   <= '0;
      commit_pend <= 1'b0;
      lat_pend    <= '0;
      term_bytes  <= '0;
    end else begin
      commit_pend <= 1'b0;
      if (is_start && state != S_DROP) begin
        w      <= 16'd1;
        chk_ok <= 1'b1;
      end else if (state == S_HDR) begin
        if (w != '1) w <= w + 16'd1;
        case (w)
          16'd2: if (!(lane(xgmii_rxd, 4) == 8'h08 && lane(xgmii_rxd, 5) == 8'h00 &&
                       lane(xgmii_rxd, 6) == 8'h45)) chk_ok <= 1'b0;
          16'd3: if (lane(xgmii_rxd, 7) != 8'h11) chk_ok <= 1'b0;
          16'd4: ip_shadow <= {lane(xgmii_rxd, 2), lane(xgmii_rxd, 3),
                               lane(xgmii_rxd, 4), lane(xgmii_rxd, 5)};
          16'd5: if ({lane(xgmii_rxd, 4), lane(xgmii_rxd, 5)} != UDP_PORT) chk_ok <= 1'b0;
          16'd6: begin
            ts_b3 <= lane(xgmii_rxd, 7);
            if ({lane(xgmii_rxd, 2), lane(xgmii_rxd, 3), lane(xgmii_rxd, 4),
                 lane(xgmii_rxd, 5), lane(xgmii_rxd, 6)} != MAGIC_CODE) chk_ok <= 1'b0;
          end
          16'd7: begin
            commit_pend <= chk_ok && (xgmii_rxc == 8'h00);
            lat_pend    <= lat_sat;
          end
          default: ;
        endcase
        if (term_found && !err_fe)
          term_bytes <= 32'({w - 16'd1, 3'b000}) + 32'(term_k);
      end
    end
  end

  assign inc_f = (state == S_TERM);
  assign inc_b = inc_f ? term_bytes : '0;

  // Per-second windows: an increment landing on the sec_oneshot cycle seeds the new window.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_acc      <= '0;
      byte_acc       <= '0;
      probe_acc      <= '0;
      rx_pps         <= '0;
      rx_throughput  <= '0;
      rx_probe_count <= '0;
      rx_latency     <= '0;
      rx_probe_valid <= 1'b0;
      rx_ipv4_ip     <= '0;
    end else begin
      rx_probe_valid <= commit_pend;
      if (commit_pend) begin
        rx_latency <= lat_pend;
        rx_ipv4_ip <= ip_shadow;
      end
      if (sec_oneshot) begin
        rx_pps         <= frame_acc;
        rx_throughput  <= byte_acc;
        rx_probe_count <= probe_acc;
        frame_acc      <= {31'd0, inc_f};
        byte_acc       <= inc_b;
        probe_acc      <= {31'd0, commit_pend};
      end else begin
        frame_acc <= sat_add(frame_acc, {31'd0, inc_f});
        byte_acc  <= sat_add(byte_acc, inc_b);
        probe_acc <= sat_add(probe_acc, {31'd0, commit_pend});
      end
    end
  end

`ifdef PROBE_RX_MINMAX_EN
  logic [23:0] win_min, win_max;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      win_min        <= '1;
      win_max        <= '0;
      rx_latency_min <= '0;
      rx_latency_max <= '0;
    end else if (sec_oneshot) begin
      rx_latency_min <= (probe_acc == '0) ? '0 : win_min;
      rx_latency_max <= (probe_acc == '0) ? '0 : win_max;
      win_min        <= commit_pend ? lat_pend : '1;
      win_max        <= commit_pend ? lat_pend : '0;
    end else if (commit_pend) begin
      if (lat_pend < win_min) win_min <= lat_pend;
      if (lat_pend > win_max) win_max <= lat_pend;
    end
  end
`endif

endmodule
